// File: rtl/freq_meter_if.sv
// Frequency meter bus: measurement controls in, BCD result out.
// Master drives en/sig_in; slave (the meter) drives bcd/valid/ovf.
interface freq_meter_if;
  logic        en;
  logic        sig_in;
  logic [15:0] bcd;
  logic        valid;
  logic        ovf;

  modport master (
    output en,
    output sig_in,
    input  bcd,
    input  valid,
    input  ovf
  );

  modport slave (
    input  en,
    input  sig_in,
    output bcd,
    output valid,
    output ovf
  );
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter with 4-digit BCD result per gate window.
// Define FREQ_METER_SAT_EN to saturate at 9999 and flag overflow.
module freq_meter #(
  parameter int GATE_CYCLES = 100000,
  parameter int GATE_W      = 17
) (
  input  logic          clk,
  input  logic          rst,
  freq_meter_if.slave   bus
);

  localparam logic [GATE_W-1:0] LAST =
    GATE_W'(GATE_CYCLES - 1);

  logic              sync1;
  logic              sync2;
  logic              hist;
  logic              edge_ev;
  logic              term;
  logic [GATE_W-1:0] gate;
  logic [15:0]       acc;
  logic [15:0]       acc_inc;
  logic [15:0]       acc_next;
  logic [15:0]       bcd_q;
  logic              valid_q;

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign edge_ev = sync2 & ~hist;
  assign term    = bus.en && (gate == LAST);
  assign acc_inc = edge_ev ? bcd_inc(acc) : acc;

`ifdef FREQ_METER_SAT_EN
  logic sat_hit;
  logic ovf_win;
  logic ovf_q;

  assign sat_hit  = edge_ev && (acc == 16'h9999);
  assign acc_next = sat_hit ? acc : acc_inc;
  assign bus.ovf  = ovf_q;

  // Sticky per-window overflow, handed to ovf with the bcd load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_win <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (!bus.en || term) begin
        ovf_win <= 1'b0;
      end else if (sat_hit) begin
        ovf_win <= 1'b1;
      end
      if (term) begin
        ovf_q <= ovf_win | sat_hit;
      end
    end
  end
`else
  assign acc_next = acc_inc;
  assign bus.ovf  = 1'b0;
`endif

  assign bus.bcd   = bcd_q;
  assign bus.valid = valid_q;

  // Two-flop synchronizer plus history flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= bus.sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Gate counter: held at 0 while disabled, wraps after LAST.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      gate <= '0;
    end else if (term) begin
      gate <= '0;
    end else begin
      gate <= gate + GATE_W'(1);
    end
  end

  // Edge accumulator; clears on the terminal cycle.
  always_ff @(posedge clk) begin
    if (rst || !bus.en || term) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  // Result register; terminal-cycle edge is included via acc_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= term;
      if (term) begin
        bcd_q <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter against an edge-count model.
// A second 30000-cycle instance checks wrap/saturation.
module tb_freq_meter;

  localparam int G  = 100;
  localparam int GB = 30000;

  logic clk;
  logic rst;
  logic en;
  logic en_big;
  logic sig;

  int n_tests;
  int n_fail;

  freq_meter_if bus ();
  freq_meter_if bus_big ();

  assign bus.en         = en;
  assign bus.sig_in     = sig;
  assign bus_big.en     = en_big;
  assign bus_big.sig_in = sig;

  freq_meter #(
    .GATE_CYCLES (G),
    .GATE_W      (7)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  freq_meter #(
    .GATE_CYCLES (GB),
    .GATE_W      (15)
  ) u_big (
    .clk (clk),
    .rst (rst),
    .bus (bus_big)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10),
            4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Reference: count rising edges of the 3-cycle-delayed
  // samples over each full window of G enabled cycles.
  int          m_pos;
  int          m_cnt;
  logic [2:0]  m_s;
  logic        m_ev;
  logic        m_valid;
  logic [15:0] m_bcd;
  logic        m_ovf;

  always @(posedge clk) begin
    m_ev    = m_s[1] & ~m_s[2];
    m_valid = 1'b0;
    if (rst) begin
      m_s   = 3'b000;
      m_pos = 0;
      m_cnt = 0;
      m_bcd = 16'h0000;
      m_ovf = 1'b0;
    end else begin
      if (en) begin
        m_cnt = m_cnt + int'(m_ev);
        if (m_pos == G - 1) begin
          m_valid = 1'b1;
`ifdef FREQ_METER_SAT_EN
          m_bcd = (m_cnt > 9999) ? 16'h9999
                                 : to_bcd(m_cnt);
          m_ovf = (m_cnt > 9999);
`else
          m_bcd = to_bcd(m_cnt % 10000);
          m_ovf = 1'b0;
`endif
          m_pos = 0;
          m_cnt = 0;
        end else begin
          m_pos++;
        end
      end else begin
        m_pos = 0;
        m_cnt = 0;
      end
      m_s = {m_s[1:0], sig};
    end
  end

  task automatic step();
    @(negedge clk);
    check("valid", 32'(bus.valid), 32'(m_valid));
    check("bcd", 32'(bus.bcd), 32'(m_bcd));
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask

  task automatic wait_valid(input int lim, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.valid && k < lim);
  endtask

  int k;
  int nv;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_s     = 3'b000;
    m_pos   = 0;
    m_cnt   = 0;
    m_bcd   = 16'h0000;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    rst     = 1'b1;
    en      = 1'b0;
    en_big  = 1'b0;
    sig     = 1'b0;

    // Reset state
    step();
    step();
    check("rst_bcd", 32'(bus.bcd), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);

    // Idle input: first valid 100 cycles after rst drops
    rst = 1'b0;
    en  = 1'b1;
    wait_valid(200, k);
    check("first_valid_lat", 32'(k), 32'(G));
    check("idle_bcd", 32'(bus.bcd), 32'h0);
    wait_valid(200, k);
    check("idle_period", 32'(k), 32'(G));

    // Period-4 square wave: 25 edges per window
    nv = 0;
    for (int i = 0; i < 500; i++) begin
      sig = (i % 4) < 2;
      step();
      if (i > 150 && bus.valid) begin
        nv++;
        check("sq4_bcd", 32'(bus.bcd), 32'h0025);
      end
    end
    check("sq4_nvalid", 32'(nv >= 3), 32'h1);

    // Single pulse landing on the terminal cycle
    sig = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2 * G; i++) begin
      sig = (i == G - 3);
      step();
      if (i == G - 1) begin
        check("term_valid", 32'(bus.valid), 32'h1);
        check("term_bcd", 32'(bus.bcd), 32'h0001);
      end
      if (i == 2 * G - 1) begin
        check("term_next_valid", 32'(bus.valid), 32'h1);
        check("term_next_bcd", 32'(bus.bcd), 32'h0000);
      end
    end

    // en gap of 37 cycles mid-window
    for (int i = 0; i < 40; i++) begin
      sig = (i % 6) < 3;
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      sig = (i % 6) < 3;
      step();
    end
    en = 1'b1;
    wait_valid(200, k);
    check("gap_relatency", 32'(k), 32'(G));

    // rst at cycle 50 of a window with edges counted
    for (int i = 0; i < 50; i++) begin
      sig = (i % 4) < 2;
      step();
    end
    rst = 1'b1;
    step();
    check("abort_bcd", 32'(bus.bcd), 32'h0);
    rst = 1'b0;
    sig = 1'b0;
    wait_valid(200, k);
    check("abort_lat", 32'(k), 32'(G));

    // Randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      int mode;
      int len;
      int per;
      mode = $urandom_range(0, 5);
      len  = $urandom_range(20, 160);
      per  = $urandom_range(2, 9);
      case (mode)
        0: begin
          for (int i = 0; i < len; i++) begin
            sig = ($urandom_range(0, 3) == 0);
            step();
          end
        end
        1: begin
          for (int i = 0; i < len; i++) begin
            sig = (i % per) < (per / 2);
            step();
          end
        end
        2: begin
          en = 1'b0;
          for (int i = 0; i < $urandom_range(1, 60); i++) begin
            sig = $urandom_range(0, 1) == 1;
            step();
          end
          en = 1'b1;
        end
        3: begin
          rst = 1'b1;
          step();
          rst = 1'b0;
        end
        default: begin
          for (int i = 0; i < len; i++) begin
            sig = $urandom_range(0, 1) == 1;
            step();
          end
        end
      endcase
    end

    // Long window, period-2 input: 15000 edges
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sig = ~sig;
      step();
    end
    en_big = 1'b1;
    k = 0;
    do begin
      sig = ~sig;
      step();
      k++;
    end while (!bus_big.valid && k < GB + 10);
    check("big_lat", 32'(k), 32'(GB));
`ifdef FREQ_METER_SAT_EN
    check("big_bcd", 32'(bus_big.bcd), 32'h9999);
    check("big_ovf", 32'(bus_big.ovf), 32'h1);
`else
    check("big_bcd", 32'(bus_big.bcd), 32'h5000);
    check("big_ovf", 32'(bus_big.ovf), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000, gate window length in clk cycles, legal range 2..131071.
REQ-002 Parameter GATE_W, default 17, gate counter width, SHALL satisfy 2^GATE_W > GATE_CYCLES.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  measurement enable, synchronous to clk.
REQ-006 sig_in  input  1  measured signal, asynchronous to clk.
REQ-007 bcd  output  16  last completed count as 4 BCD digits; [15:12] thousands, [3:0] units.
REQ-008 valid  output  1  one-cycle strobe; bcd/ovf updated this cycle.
REQ-009 ovf  output  1  last window exceeded 9999 edges.

Function
REQ-010 sig_in SHALL pass a 2-flop synchronizer and a third history flop; an edge event is sync=1 and hist=0.
REQ-011 Latency from a sig_in rise (setup met) to its edge event SHALL be 3 clk cycles.
REQ-012 Gate counter SHALL count 0..GATE_CYCLES-1 while en=1, then wrap to 0; the cycle at GATE_CYCLES-1 is the terminal cycle.
REQ-013 Accumulator SHALL be a 4-digit BCD counter incrementing by one per edge event, each digit rolling 9->0 with carry to the next.
REQ-014 On the terminal cycle, the accumulator value including any edge event in that same cycle SHALL be loaded into bcd on the following edge, with valid=1 for exactly that one cycle.
REQ-015 On the terminal cycle the accumulator SHALL clear to 0; the next window's edges start counting on the following cycle, so no edge is lost or double-counted across windows.
REQ-016 Each window SHALL contain exactly GATE_CYCLES cycles of edge sampling; consecutive valid strobes SHALL be GATE_CYCLES cycles apart while en stays 1.
REQ-017 en=0 SHALL hold the gate counter and accumulator at 0, suppress valid, and keep bcd/ovf at their last values; the synchronizer SHALL keep running.
REQ-018 The 0->1 transition of en SHALL start a new window with gate counter 0 on the first cycle en=1 is sampled; partial windows SHALL never produce valid.
REQ-019 sig_in toggling faster than clk/2 SHALL be undercounted without error indication; this is by design.

Reset
REQ-020 rst=1 SHALL clear synchronizer, history flop, gate counter, accumulator, bcd=16'h0000, valid=0, ovf=0 on the next posedge clk.
REQ-021 rst SHALL override en and any in-progress window; the aborted window SHALL produce no valid.
REQ-022 After rst is deasserted with en=1, the first valid SHALL occur GATE_CYCLES cycles after the first cycle rst=0 is sampled.

Configuration
REQ-023 Macro FREQ_METER_SAT_EN defined: the accumulator SHALL saturate at 9999, further edges set a sticky window-overflow bit, and that bit SHALL be transferred to ovf with the bcd load (cleared with the accumulator).
REQ-024 FREQ_METER_SAT_EN undefined: the accumulator SHALL wrap 9999->0000 (count modulo 10000) and ovf SHALL be tied to 0; all other behaviour is unchanged.

Verification (GATE_CYCLES=100 unless stated)
REQ-025 rst for 2 cycles, en=1, sig_in=0 -> valid every 100 cycles, bcd=16'h0000, ovf=0.
REQ-026 sig_in square wave period 4 clk, en=1 -> steady-state bcd=16'h0025 on every valid.
REQ-027 Single sig_in pulse timed so its edge event lands on the terminal cycle -> counted in the window just closing (bcd=16'h0001), next window bcd=16'h0000.
REQ-028 GATE_CYCLES=30000, sig_in period 2 clk -> with FREQ_METER_SAT_EN bcd=16'h9999, ovf=1; without it bcd=16'h5000, ovf=0.
REQ-029 en dropped for 37 cycles mid-window then reasserted -> no valid during the gap, bcd holds, next valid exactly 100 cycles after en=1 is sampled.
REQ-030 rst pulsed at cycle 50 of a window with 12 edges counted -> no valid for that window, bcd=16'h0000, first valid 100 cycles after rst deasserts.
